// File: rtl/spi_slave_multimode.sv
// SPI slave supporting all four CPOL/CPHA modes, configurable word width and bit order,
// back-to-back words per frame via a TX holding register, and underrun/overrun/abort flags.
module spi_slave_multimode #(
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter bit                   LSB_FIRST   = 1'b0,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_DEFAULT = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ready,
  output logic                  o_busy,
  output logic                  o_underrun,
  output logic                  o_overrun,
  output logic                  o_frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_prev, cs_prev;
  logic sclk_s, cs_s, mosi_s;

  state_t state_q, state_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, hold_q, hold_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic tx_ready_q, tx_ready_d, pend_src_q, pend_src_d;
  logic rx_valid_q, rx_valid_d, rx_pend_q, rx_pend_d;
  logic underrun_q, underrun_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic miso_q, miso_d, busy_q, busy_d;

  logic sclk_rise, sclk_fall, lead, trail, sample, shift;
  logic cs_fall, cs_rise, word_start, word_src, consume;
  logic [DATA_WIDTH-1:0] tx_shifted, rx_shifted, hold_word;

  // Sync chains; CS resets to "low" so a frame needs a high level seen after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev;
  assign sclk_fall  = ~sclk_s & sclk_prev;
  assign cs_fall    = cs_prev & ~cs_s;
  assign cs_rise    = ~cs_prev & cs_s;
  assign lead       = cpol_q ? sclk_fall : sclk_rise;
  assign trail      = cpol_q ? sclk_rise : sclk_fall;
  assign sample     = cpha_q ? trail : lead;
  assign shift      = cpha_q ? lead : trail;
  assign word_start = lead && (cnt_q == '0);
  assign hold_word  = tx_ready_q ? TX_DEFAULT : hold_q;
  assign tx_shifted = LSB_FIRST ? {1'b0, tx_sh_q[DATA_WIDTH-1:1]}
                                : {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
  assign rx_shifted = LSB_FIRST ? {mosi_s, rx_sh_q[DATA_WIDTH-1:1]}
                                : {rx_sh_q[DATA_WIDTH-2:0], mosi_s};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      cnt_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      tx_ready_q  <= 1'b1;
      pend_src_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_pend_q   <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      cnt_q       <= cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      tx_ready_q  <= tx_ready_d;
      pend_src_q  <= pend_src_d;
      rx_valid_q  <= rx_valid_d;
      rx_pend_q   <= rx_pend_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
    end
  end

  // TX words are committed (consumed or flagged as underrun) at the first leading edge of a word;
  // with CPHA=0 the word is pre-shown on MISO earlier, remembering whether it came from the hold.
  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    cnt_d       = cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    hold_d      = hold_q;
    rx_data_d   = rx_data_q;
    tx_ready_d  = tx_ready_q;
    pend_src_d  = pend_src_q;
    rx_valid_d  = 1'b0;
    rx_pend_d   = i_rx_ready ? 1'b0 : rx_pend_q;
    underrun_d  = 1'b0;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    word_src    = 1'b0;
    consume     = 1'b0;

    case (state_q)
      IDLE: begin
        cpol_d = i_cpol;
        cpha_d = i_cpha;
        cnt_d  = '0;
        if (cs_fall) begin
          state_d    = ACTIVE;
          tx_sh_d    = hold_word;
          pend_src_d = ~tx_ready_q;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d     = IDLE;
          cnt_d       = '0;
          frame_err_d = (cnt_q != '0);
        end else begin
          if (word_start) begin
            if (cpha_q) begin
              tx_sh_d  = hold_word;
              word_src = ~tx_ready_q;
            end else begin
              word_src = pend_src_q;
            end
            consume    = word_src;
            underrun_d = ~word_src;
          end else if (shift) begin
            if (!cpha_q && (cnt_q == '0)) begin
              tx_sh_d    = hold_word;
              pend_src_d = ~tx_ready_q;
            end else begin
              tx_sh_d = tx_shifted;
            end
          end
          if (sample) begin
            rx_sh_d = rx_shifted;
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              cnt_d      = '0;
              rx_data_d  = rx_shifted;
              rx_valid_d = 1'b1;
              overrun_d  = rx_pend_q & ~i_rx_ready;
              rx_pend_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) tx_ready_d = 1'b1;
    if (i_tx_valid && (tx_ready_q || consume)) begin
      hold_d     = i_tx_data;
      tx_ready_d = 1'b0;
    end

    busy_d = (state_d == ACTIVE);
    miso_d = busy_d & (LSB_FIRST ? tx_sh_d[0] : tx_sh_d[DATA_WIDTH-1]);
  end

  assign o_miso      = miso_q;
  assign o_busy      = busy_q;
  assign o_tx_ready  = tx_ready_q;
  assign o_rx_data   = rx_data_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_underrun  = underrun_q;
  assign o_overrun   = overrun_q;
  assign o_frame_err = frame_err_q;

endmodule
